// File: rtl/hs_byte_packer.sv
// Packs RATIO narrow valid/ready beats into one wide word carrying keep and last.
// Optional idle flush of partial words: define HS_PACK_FLUSH_TIMEOUT_EN.
module hs_byte_packer #(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4,
    parameter int TIMEOUT  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      up_valid,
    input  logic [IN_WIDTH-1:0]       up_data,
    input  logic                      up_last,
    output logic                      up_ready,
    output logic                      down_valid,
    output logic [IN_WIDTH*RATIO-1:0] down_data,
    output logic [RATIO-1:0]          down_keep,
    output logic                      down_last,
    input  logic                      down_ready
);
    localparam int OW = IN_WIDTH * RATIO;
    localparam int IW = (RATIO > 1) ? $clog2(RATIO) : 1;

    // Valid/ready: a beat or word moves on a rising edge where both valid and
    // ready are high; valid never waits on ready and data holds while stalled.

    logic [OW-1:0]    acc_data;
    logic [RATIO-1:0] acc_keep;
    logic             acc_last;
    logic [IW-1:0]    idx;
    logic             pending;

    logic [OW-1:0]    word_data;
    logic [RATIO-1:0] word_keep;
    logic             accept;
    logic             slot_free;
    logic             lane_end;

`ifdef HS_PACK_FLUSH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] idle_cnt;
`endif

    // up_ready depends only on the pending register, never on down_ready.
    assign up_ready  = !pending;
    assign accept    = up_valid && up_ready;
    assign slot_free = !down_valid || down_ready;
    assign lane_end  = (idx == IW'(RATIO - 1));

    // Accumulator with the current beat merged into lane idx.
    always_comb begin
        word_data = acc_data;
        word_data[int'(idx)*IN_WIDTH +: IN_WIDTH] = up_data;
        word_keep = acc_keep;
        word_keep[idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            down_valid <= 1'b0;
            down_data  <= '0;
            down_keep  <= '0;
            down_last  <= 1'b0;
            acc_data   <= '0;
            acc_keep   <= '0;
            acc_last   <= 1'b0;
            idx        <= '0;
            pending    <= 1'b0;
`ifdef HS_PACK_FLUSH_TIMEOUT_EN
            idle_cnt   <= '0;
`endif
        end else begin
            if (down_valid && down_ready)
                down_valid <= 1'b0;
`ifdef HS_PACK_FLUSH_TIMEOUT_EN
            idle_cnt <= '0;
`endif
            if (pending) begin
                if (slot_free) begin
                    down_valid <= 1'b1;
                    down_data  <= acc_data;
                    down_keep  <= acc_keep;
                    down_last  <= acc_last;
                    acc_data   <= '0;
                    acc_keep   <= '0;
                    acc_last   <= 1'b0;
                    pending    <= 1'b0;
                end
            end else if (accept) begin
                if (lane_end || up_last) begin
                    idx <= '0;
                    if (slot_free) begin
                        down_valid <= 1'b1;
                        down_data  <= word_data;
                        down_keep  <= word_keep;
                        down_last  <= up_last;
                        acc_data   <= '0;
                        acc_keep   <= '0;
                    end else begin
                        acc_data <= word_data;
                        acc_keep <= word_keep;
                        acc_last <= up_last;
                        pending  <= 1'b1;
                    end
                end else begin
                    acc_data <= word_data;
                    acc_keep <= word_keep;
                    idx      <= idx + 1'b1;
                end
            end
`ifdef HS_PACK_FLUSH_TIMEOUT_EN
            else if (idx != '0) begin
                // Idle partial word: close it without last once the count expires.
                if (idle_cnt == CW'(TIMEOUT - 1)) begin
                    idx <= '0;
                    if (slot_free) begin
                        down_valid <= 1'b1;
                        down_data  <= acc_data;
                        down_keep  <= acc_keep;
                        down_last  <= 1'b0;
                        acc_data   <= '0;
                        acc_keep   <= '0;
                    end else begin
                        acc_last <= 1'b0;
                        pending  <= 1'b1;
                    end
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_hs_byte_packer.sv
// Scoreboarded bench for hs_byte_packer (RATIO=4, IN_WIDTH=8, TIMEOUT=16).
module tb_hs_byte_packer;
    localparam int W  = 8;
    localparam int R  = 4;
    localparam int EW = 1 + R + W * R;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           up_valid = 1'b0;
    logic [W-1:0]   up_data = '0;
    logic           up_last = 1'b0;
    logic           up_ready;
    logic           down_valid;
    logic [W*R-1:0] down_data;
    logic [R-1:0]   down_keep;
    logic           down_last;
    logic           down_ready = 1'b1;

    logic [EW-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int stall_cnt = 0;
    int cyc = 0;

    hs_byte_packer #(.IN_WIDTH(W), .RATIO(R), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .up_valid(up_valid), .up_data(up_data), .up_last(up_last), .up_ready(up_ready),
        .down_valid(down_valid), .down_data(down_data), .down_keep(down_keep),
        .down_last(down_last), .down_ready(down_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: a word that will transfer at the next rising edge is popped here.
    always @(negedge clk) begin
        if (rst_n && down_valid && down_ready) begin
            logic [EW-1:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word got data=%h keep=%b last=%b, required none",
                         down_data, down_keep, down_last);
            end else begin
                e = exp_q.pop_front();
                if ({down_last, down_keep, down_data} !== e) begin
                    errors++;
                    $display("FAIL word got last=%b keep=%b data=%h, required last=%b keep=%b data=%h",
                             down_last, down_keep, down_data, e[EW-1], e[EW-2 -: R], e[W*R-1:0]);
                end
            end
        end
    end

    task automatic push_exp(input logic last, input logic [R-1:0] keep, input logic [W*R-1:0] data);
        exp_q.push_back({last, keep, data});
    endtask

    task automatic send_beat(input logic [W-1:0] d, input logic l);
        int n = 0;
        up_valid = 1'b1;
        up_data  = d;
        up_last  = l;
        @(negedge clk);
        while (!up_ready && n < 200) begin
            stall_cnt++;
            n++;
            @(negedge clk);
        end
        checks++;
        if (!up_ready) begin
            errors++;
            $display("FAIL send_timeout beat %h not accepted within 200 cycles", d);
        end
        @(posedge clk);
        #1;
        up_valid = 1'b0;
        up_last  = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got %0d words outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({down_valid, down_keep, down_last, down_data} !== '0 || up_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset got valid=%b keep=%b last=%b data=%h ready=%b, required all 0 ready=1",
                     down_valid, down_keep, down_last, down_data, up_ready);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_word;
        push_exp(1'b1, 4'b1111, 32'h44332211);
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b0);
        send_beat(8'h33, 1'b0);
        checks++;
        if (down_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_early got down_valid=%b, required 0", down_valid);
        end
        send_beat(8'h44, 1'b1);
        checks++;
        if (down_valid !== 1'b1 || down_data !== 32'h44332211 || down_keep !== 4'b1111 || down_last !== 1'b1) begin
            errors++;
            $display("FAIL full_latency got valid=%b data=%h keep=%b last=%b, required 1 44332211 1111 1",
                     down_valid, down_data, down_keep, down_last);
        end
        wait_drain("full");
    endtask

    task automatic test_short_packet;
        push_exp(1'b1, 4'b0011, 32'h0000BBAA);
        push_exp(1'b1, 4'b0001, 32'h000000CC);
        send_beat(8'hAA, 1'b0);
        send_beat(8'hBB, 1'b1);
        send_beat(8'hCC, 1'b1);
        wait_drain("short");
    endtask

    task automatic test_backpressure;
        down_ready = 1'b0;
        push_exp(1'b0, 4'b1111, 32'h04030201);
        push_exp(1'b0, 4'b1111, 32'h08070605);
        for (int i = 1; i <= 8; i++) send_beat(W'(i), 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (down_valid !== 1'b1 || down_data !== 32'h04030201 || up_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold got valid=%b data=%h up_ready=%b, required 1 04030201 0",
                         down_valid, down_data, up_ready);
            end
            @(posedge clk);
            #1;
        end
        down_ready = 1'b1;
        wait_drain("bp");
        checks++;
        if (up_ready !== 1'b1 || down_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got up_ready=%b down_valid=%b, required 1 0", up_ready, down_valid);
        end
    endtask

    task automatic test_back_to_back;
        int start;
        down_ready = 1'b1;
        stall_cnt = 0;
        for (int w = 0; w < 4; w++) begin
            logic [W*R-1:0] d = '0;
            for (int b = 0; b < R; b++) d[b*W +: W] = W'(8'h40 + w * R + b);
            push_exp(1'b0, 4'b1111, d);
        end
        start = cyc;
        for (int i = 0; i < 16; i++) send_beat(W'(8'h40 + i), 1'b0);
        checks++;
        if (stall_cnt != 0 || cyc - start != 16) begin
            errors++;
            $display("FAIL stream got stalls=%0d cycles=%0d, required 0 and 16", stall_cnt, cyc - start);
        end
        wait_drain("stream");
    endtask

    task automatic test_reset_mid_word;
        send_beat(8'hE1, 1'b0);
        send_beat(8'hE2, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if ({down_valid, down_keep, down_last, down_data} !== '0 || up_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset got valid=%b keep=%b last=%b data=%h, required all 0",
                     down_valid, down_keep, down_last, down_data);
        end
        push_exp(1'b0, 4'b1111, 32'h13121110);
        for (int i = 0; i < 4; i++) send_beat(W'(8'h10 + i), 1'b0);
        wait_drain("midreset");
    endtask

    task automatic test_timeout;
        int n = 0;
        send_beat(8'h5A, 1'b0);
`ifdef HS_PACK_FLUSH_TIMEOUT_EN
        push_exp(1'b0, 4'b0001, 32'h0000005A);
        while (!down_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL timeout_latency got %0d idle cycles, required 16", n);
        end
        wait_drain("timeout");
`else
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (down_valid) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL no_timeout got %0d valid cycles, required 0", n);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
`endif
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_short_packet();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_word();
        test_timeout();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover got %0d queued words, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
